arbiter: RTL and testbench
==========================

ARBITER -- requirements
Module: arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4, is the maximum consecutive grant cycles per requester when timeout is compiled in; legal range 1..15.
REQ-002 Port clk, input, 1 bit, is the single clock; all state changes occur on its rising edge.
REQ-003 Port rst, input, 1 bit, is the asynchronous active-low reset.
REQ-004 Port request, input, 2 bits: bit i high means requester i wants the resource.
REQ-005 Port grant, output, 2 bits, is registered: bit i high means requester i owns the resource; the value is one-hot or 00.

Function
REQ-006 The FSM SHALL have three states, IDLE (grant=00), GNT0 (grant=01) and GNT1 (grant=10); grant SHALL be decoded from state only.
REQ-007 grant SHALL NEVER be 11, including during reset and on switch edges.
REQ-008 Latency: request sampled at rising edge N SHALL be reflected on grant after edge N; there is no combinational path from request to grant.
REQ-009 In IDLE, one request bit high SHALL move the FSM to that GNT state.
REQ-010 In IDLE with request=11, the requester not served last SHALL win; the last-served pointer resets to 1, so requester 0 wins first after reset.
REQ-011 In IDLE with request=00, the FSM SHALL stay in IDLE.
REQ-012 In GNTx with request[x]=1, the FSM SHALL hold GNTx; there is no preemption except REQ-017.
REQ-013 In GNTx with request[x]=0 sampled: if the other bit is 1, the FSM SHALL go directly to the other GNT state with no 00 bubble; otherwise it SHALL go to IDLE.
REQ-014 The last-served pointer SHALL update to x on every entry into GNTx.
REQ-015 Requests from a non-granted requester SHALL be held off without loss; the bench holds them, and the block does not latch them.

Reset
REQ-016 rst=0 SHALL immediately, with no clock edge, force grant=00, state=IDLE, last-served=1, hold counter=0; the first decision occurs at the first rising edge with rst=1 sampled.

Configuration
REQ-017 With ARB_TIMEOUT_EN defined, a 4-bit hold counter SHALL behave as follows:
- It loads 1 on entry into GNTx and increments each edge the FSM stays in GNTx.
- When the counter equals MAX_HOLD and the other request bit is 1 at an edge, the FSM SHALL switch to the other GNT state, so a grant lasts exactly MAX_HOLD cycles under contention.
- If the other request bit is 0, the grant SHALL continue and the counter saturates at MAX_HOLD.
REQ-018 Without ARB_TIMEOUT_EN, no counter logic SHALL be present, MAX_HOLD SHALL be ignored, and a holder SHALL keep the grant for as long as its request stays high.

Verification
REQ-019 Reset release, request<=01 after edge 1 -> grant=01 after edge 2, still 01 when checked after edge 3.
REQ-020 From IDLE, request=11 -> grant=01; then request=10 -> grant=10 after the next edge, with no 00 cycle between.
REQ-021 Macro off, request=11 held 20 cycles -> grant stays 01 for all 20; then request=00 -> grant=00 after one edge.
REQ-022 Macro on, MAX_HOLD=4, request=11 held -> grant is 01 for 4 cycles, then 10 for 4, alternating; request=01 held alone -> grant stays 01 beyond 4 cycles.
REQ-023 rst driven low mid-cycle while grant=10 -> grant=00 before the next edge; after release, request=11 -> grant=01 because the pointer is reset.
REQ-024 Sweep all 16 pairs of (previous request, current request) from each state -> grant is never 11 and matches REQ-009 to REQ-013.

Source files
------------

// File: rtl/arbiter.sv
// arbiter: two-requester FSM arbiter with last-served tie-break and no bubble on handover.
// Define ARB_TIMEOUT_EN to compile in the MAX_HOLD hold-time limit under contention.
module arbiter #(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] request,
   output logic [1:0] grant
);
   typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;
   state_t state_q, state_d;
   logic   last_q, last_d;
   logic   expired;
   if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
      $error("arbiter: MAX_HOLD must be in 1..15");
   end
`ifdef ARB_TIMEOUT_EN
   localparam logic [3:0] MAX = 4'(MAX_HOLD);
   logic [3:0] cnt_q, cnt_d;
   assign expired = cnt_q == MAX;
   always_comb cnt_d = state_d == IDLE ? 4'd0 : state_d != state_q ? 4'd1 : expired ? MAX : cnt_q + 4'd1;
`else
   assign expired = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= 4'd0;
`endif
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end
   // A holder leaves when it drops its request or has used up its hold time while the other waits.
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE:    state_d = request[0] && (!request[1] || last_q) ? GNT0 : request[1] ? GNT1 : IDLE;
         GNT0:    state_d = request[0] && !(expired && request[1]) ? GNT0 : request[1] ? GNT1 : IDLE;
         GNT1:    state_d = request[1] && !(expired && request[0]) ? GNT1 : request[0] ? GNT0 : IDLE;
         default: state_d = IDLE;
      endcase
      last_d = state_d == GNT0 ? 1'b0 : state_d == GNT1 ? 1'b1 : last_q;
   end
   always_comb grant = {state_q == GNT1, state_q == GNT0};
endmodule

// File: tb/tb_arbiter.sv
// tb_arbiter: directed checks of reset, handover, hold behaviour and a state/request sweep.
module tb_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] request = 2'b00;
   logic [1:0] grant;
   int         tests = 0;
   int         fails = 0;

   arbiter #(.MAX_HOLD(4)) dut (.clk(clk), .rst(rst), .request(request), .grant(grant));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #2 rst = 1'b0;
      request = 2'b00;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      request = 2'b11;
      tick();
      tick();
      tests++;
      if (grant !== 2'b00) begin fails++; $display("FAIL reset_hold: grant=%b expected 00", grant); end
      rst = 1'b1;
      request = 2'b00;
      tick();
      tests++;
      if (grant !== 2'b00) begin fails++; $display("FAIL release_edge1: grant=%b expected 00", grant); end
      request = 2'b01;
      tick();
      tests++;
      if (grant !== 2'b01) begin fails++; $display("FAIL release_edge2: grant=%b expected 01", grant); end
      tick();
      tests++;
      if (grant !== 2'b01) begin fails++; $display("FAIL release_edge3: grant=%b expected 01", grant); end
      request = 2'b00;
      tick();
      tests++;
      if (grant !== 2'b00) begin fails++; $display("FAIL release_drop: grant=%b expected 00", grant); end
   endtask

   task automatic test_handover();
      do_reset();
      request = 2'b11;
      tick();
      tests++;
      if (grant !== 2'b01) begin fails++; $display("FAIL contend_first: grant=%b expected 01", grant); end
      request = 2'b10;
      tick();
      tests++;
      if (grant !== 2'b10) begin fails++; $display("FAIL handover_no_bubble: grant=%b expected 10", grant); end
      request = 2'b00;
      tick();
      tests++;
      if (grant !== 2'b00) begin fails++; $display("FAIL handover_idle: grant=%b expected 00", grant); end
      request = 2'b11;
      tick();
      tests++;
      if (grant !== 2'b01) begin fails++; $display("FAIL pointer_after_1: grant=%b expected 01", grant); end
      request = 2'b00;
      tick();
      request = 2'b11;
      tick();
      tests++;
      if (grant !== 2'b10) begin fails++; $display("FAIL pointer_after_0: grant=%b expected 10", grant); end
      request = 2'b01;
      tick();
      tests++;
      if (grant !== 2'b01) begin fails++; $display("FAIL handover_back: grant=%b expected 01", grant); end
   endtask

   task automatic test_hold();
      do_reset();
      request = 2'b11;
`ifdef ARB_TIMEOUT_EN
      for (int i = 0; i < 16; i++) begin
         tick();
         tests++;
         if (grant !== ((i / 4) % 2 == 0 ? 2'b01 : 2'b10)) begin
            fails++;
            $display("FAIL timeout_alternate[%0d]: grant=%b expected %b", i, grant, (i / 4) % 2 == 0 ? 2'b01 : 2'b10);
         end
      end
`else
      for (int i = 0; i < 20; i++) begin
         tick();
         tests++;
         if (grant !== 2'b01) begin fails++; $display("FAIL hold_contended[%0d]: grant=%b expected 01", i, grant); end
      end
`endif
      request = 2'b00;
      tick();
      tests++;
      if (grant !== 2'b00) begin fails++; $display("FAIL hold_release: grant=%b expected 00", grant); end
      request = 2'b01;
      for (int i = 0; i < 8; i++) begin
         tick();
         tests++;
         if (grant !== 2'b01) begin fails++; $display("FAIL hold_alone[%0d]: grant=%b expected 01", i, grant); end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      request = 2'b10;
      tick();
      tests++;
      if (grant !== 2'b10) begin fails++; $display("FAIL async_setup: grant=%b expected 10", grant); end
      #2 rst = 1'b0;
      #1;
      tests++;
      if (grant !== 2'b00) begin fails++; $display("FAIL async_clear: grant=%b expected 00", grant); end
      tick();
      #2 rst = 1'b1;
      request = 2'b11;
      tick();
      tests++;
      if (grant !== 2'b01) begin fails++; $display("FAIL async_pointer: grant=%b expected 01", grant); end
   endtask

   // Reference behaviour without timeout; sweep sequences stay below MAX_HOLD so it also holds with timeout.
   function automatic logic [1:0] model(input logic [1:0] g, input logic last, input logic [1:0] req);
      if (g == 2'b01) return req[0] ? 2'b01 : req[1] ? 2'b10 : 2'b00;
      if (g == 2'b10) return req[1] ? 2'b10 : req[0] ? 2'b01 : 2'b00;
      if (req == 2'b11) return last ? 2'b01 : 2'b10;
      return req;
   endfunction

   task automatic test_sweep();
      logic [1:0] exp_g;
      logic       exp_last;
      for (int s = 0; s < 3; s++) begin
         for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 4; c++) begin
               do_reset();
               exp_g = 2'b00;
               exp_last = 1'b1;
               if (s != 0) begin
                  request = s == 1 ? 2'b01 : 2'b10;
                  tick();
                  exp_g = request;
                  exp_last = s == 2;
               end
               request = 2'(p);
               tick();
               exp_g = model(exp_g, exp_last, request);
               exp_last = exp_g == 2'b00 ? exp_last : exp_g[1];
               tests++;
               if (grant !== exp_g || grant === 2'b11) begin
                  fails++;
                  $display("FAIL sweep_prev s%0d p%0d: grant=%b expected %b", s, p, grant, exp_g);
               end
               request = 2'(c);
               tick();
               exp_g = model(exp_g, exp_last, request);
               tests++;
               if (grant !== exp_g || grant === 2'b11) begin
                  fails++;
                  $display("FAIL sweep_cur s%0d p%0d c%0d: grant=%b expected %b", s, p, c, grant, exp_g);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_handover();
      test_hold();
      test_async_reset();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
